// File: rtl/mux_2_1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_2_1_arbiter
// Purpose  : Round-robin arbiter that owns the select line of a 2:1 datapath
//            mux shared by two valid/ready streaming requesters. A grant is
//            held for a whole packet and is capped at MAX_BURST accepted beats.
// Ports    : ARB_CLOCK_50                 - clock, rising edge
//            ARB_RESET_InLow              - synchronous reset, active low
//            ARB_ReqN_Valid/Data/Last     - requester N beat (in)
//            ARB_ReqN_Ready               - requester N beat accepted (out)
//            ARB_Out_Valid/Data/Last      - muxed beat to downstream (out)
//            ARB_Out_Ready                - downstream accepts beat (in)
//            ARB_Sel                      - registered mux select (out)
//            ARB_Grant0/ARB_Grant1        - registered one-hot grant (out)
//            ARB_Busy                     - a grant is active (out)
// Revision : 1.0 - initial release
// ============================================================================
module mux_2_1_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                  ARB_CLOCK_50,
    input  logic                  ARB_RESET_InLow,
    input  logic                  ARB_Req0_Valid,
    input  logic [DATA_WIDTH-1:0] ARB_Req0_Data,
    input  logic                  ARB_Req0_Last,
    output logic                  ARB_Req0_Ready,
    input  logic                  ARB_Req1_Valid,
    input  logic [DATA_WIDTH-1:0] ARB_Req1_Data,
    input  logic                  ARB_Req1_Last,
    output logic                  ARB_Req1_Ready,
    output logic                  ARB_Out_Valid,
    input  logic                  ARB_Out_Ready,
    output logic [DATA_WIDTH-1:0] ARB_Out_Data,
    output logic                  ARB_Out_Last,
    output logic                  ARB_Sel,
    output logic                  ARB_Grant0,
    output logic                  ARB_Grant1,
    output logic                  ARB_Busy
);

    localparam int               c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GRANT0 = 2'd1;
    localparam logic [1:0] c_GRANT1 = 2'd2;

    logic [1:0]         r_state;
    logic               r_ptr;      // last requester granted
    logic [c_CNT_W-1:0] r_cnt;      // beats accepted in the current grant
    logic               r_sel;
    logic               r_grant0;
    logic               r_grant1;
    logic               r_busy;

    logic                  w_out_valid;
    logic                  w_out_last;
    logic [DATA_WIDTH-1:0] w_mux_data;
    logic                  w_accept;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_release;
    logic                  w_go;       // start a (new) grant next cycle
    logic                  w_pick;     // requester to grant when w_go
    logic                  w_drop;     // fall back to IDLE next cycle

    // ------------------------------------------------------------------
    // Same-cycle datapath: the mux is steered only by the registered
    // select, so it cannot glitch on an in-flight beat.
    // ------------------------------------------------------------------
    always_comb begin
        w_out_valid = 1'b0;
        if (r_grant0) begin
            w_out_valid = ARB_Req0_Valid;
        end else if (r_grant1) begin
            w_out_valid = ARB_Req1_Valid;
        end
    end

    assign w_mux_data = r_sel ? ARB_Req1_Data : ARB_Req0_Data;
    assign w_out_last = r_sel ? ARB_Req1_Last : ARB_Req0_Last;

    assign ARB_Out_Valid  = w_out_valid;
    assign ARB_Out_Data   = r_busy ? w_mux_data : '0;
    assign ARB_Out_Last   = r_busy & w_out_last;
    assign ARB_Req0_Ready = r_grant0 & ARB_Out_Ready;
    assign ARB_Req1_Ready = r_grant1 & ARB_Out_Ready;

    assign ARB_Sel    = r_sel;
    assign ARB_Grant0 = r_grant0;
    assign ARB_Grant1 = r_grant1;
    assign ARB_Busy   = r_busy;

    // A beat carrying Last that also fills the burst is one release.
    assign w_accept  = w_out_valid & ARB_Out_Ready;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_release = w_accept & (ARB_Out_Last | (w_cnt_inc == c_MAX_CNT));

    // ------------------------------------------------------------------
    // Arbitration decision
    // ------------------------------------------------------------------
    always_comb begin
        w_go   = 1'b0;
        w_pick = 1'b0;
        w_drop = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (ARB_Req0_Valid && ARB_Req1_Valid) begin
                    w_go   = 1'b1;
                    w_pick = ~r_ptr;
                end else if (ARB_Req0_Valid) begin
                    w_go   = 1'b1;
                    w_pick = 1'b0;
                end else if (ARB_Req1_Valid) begin
                    w_go   = 1'b1;
                    w_pick = 1'b1;
                end
            end
            c_GRANT0: begin
                // Hand over to the other side first so it cannot starve.
                if (w_release) begin
                    if (ARB_Req1_Valid) begin
                        w_go   = 1'b1;
                        w_pick = 1'b1;
                    end else if (ARB_Req0_Valid) begin
                        w_go   = 1'b1;
                        w_pick = 1'b0;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            c_GRANT1: begin
                if (w_release) begin
                    if (ARB_Req0_Valid) begin
                        w_go   = 1'b1;
                        w_pick = 1'b0;
                    end else if (ARB_Req1_Valid) begin
                        w_go   = 1'b1;
                        w_pick = 1'b1;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            default: begin
                w_drop = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State, pointer, counter and registered output decodes
    // ------------------------------------------------------------------
    always_ff @(posedge ARB_CLOCK_50) begin
        if (!ARB_RESET_InLow) begin
            r_state  <= c_IDLE;
            r_ptr    <= 1'b1;   // requester 0 wins the first tie
            r_cnt    <= '0;
            r_sel    <= 1'b0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_go) begin
            r_state  <= w_pick ? c_GRANT1 : c_GRANT0;
            r_ptr    <= w_pick;
            r_cnt    <= '0;
            r_sel    <= w_pick;
            r_grant0 <= ~w_pick;
            r_grant1 <= w_pick;
            r_busy   <= 1'b1;
        end else if (w_drop) begin
            // Sel intentionally keeps its last value while idle.
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_grant0 <= 1'b0;
            r_grant1 <= 1'b0;
            r_busy   <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= w_cnt_inc;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_2_1_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_2_1_arbiter
// Purpose  : Self-checking bench for mux_2_1_arbiter. Requesters are fed from
//            beat queues; the expected downstream beat order is queued as the
//            stimulus is loaded and compared as beats are accepted.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_2_1_arbiter;

    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_last, req1_last;
    logic          req0_ready, req1_ready;
    logic          out_valid, out_ready, out_last;
    logic [DW-1:0] out_data;
    logic          sel, grant0, grant1, busy;

    always #5 clk = ~clk;

    mux_2_1_arbiter #(
        .DATA_WIDTH (DW),
        .MAX_BURST  (MB)
    ) u_dut (
        .ARB_CLOCK_50    (clk),
        .ARB_RESET_InLow (rst_n),
        .ARB_Req0_Valid  (req0_valid),
        .ARB_Req0_Data   (req0_data),
        .ARB_Req0_Last   (req0_last),
        .ARB_Req0_Ready  (req0_ready),
        .ARB_Req1_Valid  (req1_valid),
        .ARB_Req1_Data   (req1_data),
        .ARB_Req1_Last   (req1_last),
        .ARB_Req1_Ready  (req1_ready),
        .ARB_Out_Valid   (out_valid),
        .ARB_Out_Ready   (out_ready),
        .ARB_Out_Data    (out_data),
        .ARB_Out_Last    (out_last),
        .ARB_Sel         (sel),
        .ARB_Grant0      (grant0),
        .ARB_Grant1      (grant1),
        .ARB_Busy        (busy)
    );

    logic [8:0] src0[$];   // {last, data}
    logic [8:0] src1[$];
    logic [9:0] exp_q[$];  // {sel, last, data}
    int         total = 0;
    int         bad   = 0;
    logic       bp_chk = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_src(input logic n, input logic [7:0] d, input logic l);
        if (n) src1.push_back({l, d});
        else   src0.push_back({l, d});
    endtask

    task automatic expect_beat(input logic s, input logic [7:0] d, input logic l);
        exp_q.push_back({s, l, d});
    endtask

    task automatic drive_inputs();
        logic [8:0] h0, h1;
        h0 = (src0.size() > 0) ? src0[0] : 9'h000;
        h1 = (src1.size() > 0) ? src1[0] : 9'h000;
        req0_valid = (src0.size() > 0);
        req1_valid = (src1.size() > 0);
        req0_data  = h0[7:0];
        req0_last  = h0[8];
        req1_data  = h1[7:0];
        req1_last  = h1[8];
    endtask

    task automatic monitor();
        logic [9:0] e;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("extra_beat", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("beat_data", 32'(out_data), 32'(e[7:0]));
                check("beat_last", 32'(out_last), 32'(e[8]));
                check("beat_sel",  32'(sel),      32'(e[9]));
            end
        end else if (out_valid && exp_q.size() > 0) begin
            e = exp_q[0];
            check("stall_hold", 32'(out_data), 32'(e[7:0]));
        end
        if (bp_chk) begin
            check("bp_ready0", 32'(req0_ready), 32'(out_ready));
            check("bp_ready1", 32'(req1_ready), 32'd0);
        end
    endtask

    // One clock: drive, sample at the falling edge, retire accepted beats.
    task automatic step();
        logic       a0, a1;
        logic [8:0] dummy;
        drive_inputs();
        @(negedge clk);
        monitor();
        a0 = req0_valid & req0_ready;
        a1 = req1_valid & req1_ready;
        @(posedge clk);
        #1;
        if (a0) dummy = src0.pop_front();
        if (a1) dummy = src1.pop_front();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        src0.delete();
        src1.delete();
        exp_q.delete();
        drive_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        // ---------------- reset with both requesters valid ----------------
        rst_n     = 1'b0;
        out_ready = 1'b0;
        push_src(1'b0, 8'hA0, 1'b1);
        push_src(1'b1, 8'hB0, 1'b1);
        drive_inputs();
        repeat (3) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check("rst_outputs",
                  32'({grant0, grant1, busy, sel, out_valid, req0_ready, req1_ready, out_last, out_data}),
                  32'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_c1_grant0", 32'(grant0), 32'd0);
        check("rel_c1_grant1", 32'(grant1), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_c2_grant0", 32'(grant0), 32'd1);
        check("rel_c2_sel",    32'(sel),    32'd0);
        check("rel_c2_valid",  32'(out_valid), 32'd1);
        check("rel_c2_data",   32'(out_data),  32'hA0);

        // ---------------- single requester, 4-beat packet ----------------
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_src(1'b1, 8'(8'h11 + i), (i == 3));
            expect_beat(1'b1, 8'(8'h11 + i), (i == 3));
        end
        drive_inputs();
        @(negedge clk);
        check("s2_pre_grant1", 32'(grant1),    32'd0);
        check("s2_pre_valid",  32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        step();
        check("s2_grant1", 32'(grant1), 32'd1);
        repeat (3) step();
        check("s2_consecutive", 32'(exp_q.size()), 32'd0);
        drive_inputs();
        @(negedge clk);
        check("s2_quiet_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        // ---------------- tie, alternating 2-beat packets ----------------
        do_reset();
        out_ready = 1'b1;
        for (int p = 0; p < 3; p++) begin
            push_src(1'b0, 8'(8'h01 + 2 * p), 1'b0);
            push_src(1'b0, 8'(8'h02 + 2 * p), 1'b1);
            push_src(1'b1, 8'(8'h81 + 2 * p), 1'b0);
            push_src(1'b1, 8'(8'h82 + 2 * p), 1'b1);
            expect_beat(1'b0, 8'(8'h01 + 2 * p), 1'b0);
            expect_beat(1'b0, 8'(8'h02 + 2 * p), 1'b1);
            expect_beat(1'b1, 8'(8'h81 + 2 * p), 1'b0);
            expect_beat(1'b1, 8'(8'h82 + 2 * p), 1'b1);
        end
        repeat (13) step();
        check("s3_full_rate", 32'(exp_q.size()), 32'd0);

        // ---------------- burst cap (MAX_BURST = 4) ----------------
        do_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) push_src(1'b0, 8'(i), (i == 10));
        push_src(1'b1, 8'h81, 1'b0);
        push_src(1'b1, 8'h82, 1'b1);
        push_src(1'b1, 8'h83, 1'b0);
        push_src(1'b1, 8'h84, 1'b1);
        for (int i = 1; i <= 4; i++) expect_beat(1'b0, 8'(i), 1'b0);
        expect_beat(1'b1, 8'h81, 1'b0);
        expect_beat(1'b1, 8'h82, 1'b1);
        for (int i = 5; i <= 8; i++) expect_beat(1'b0, 8'(i), 1'b0);
        expect_beat(1'b1, 8'h83, 1'b0);
        expect_beat(1'b1, 8'h84, 1'b1);
        expect_beat(1'b0, 8'h09, 1'b0);
        expect_beat(1'b0, 8'h0A, 1'b1);
        repeat (15) step();
        check("s4_drain", 32'(exp_q.size()), 32'd0);

        // ---------------- backpressure ----------------
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_src(1'b0, 8'(8'h31 + i), (i == 5));
        push_src(1'b1, 8'h91, 1'b1);
        for (int i = 0; i < 4; i++) expect_beat(1'b0, 8'(8'h31 + i), 1'b0);
        expect_beat(1'b1, 8'h91, 1'b1);
        expect_beat(1'b0, 8'h35, 1'b0);
        expect_beat(1'b0, 8'h36, 1'b1);
        step();
        begin
            logic [3:0] bp_pat;
            bp_pat = 4'b1001;
            for (int i = 0; i < 4; i++) begin
                out_ready = bp_pat[3 - i];
                bp_chk    = 1'b1;
                step();
            end
        end
        bp_chk    = 1'b0;
        out_ready = 1'b1;
        repeat (7) step();
        check("s5_drain", 32'(exp_q.size()), 32'd0);

        // ---------------- reset mid-packet ----------------
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push_src(1'b0, 8'(8'h51 + i), (i == 4));
        expect_beat(1'b0, 8'h51, 1'b0);
        expect_beat(1'b0, 8'h52, 1'b0);
        repeat (3) step();
        rst_n     = 1'b0;
        out_ready = 1'b0;
        drive_inputs();
        @(negedge clk);
        check("s6_pre_grant0", 32'(grant0), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("s6_rst_grant0", 32'(grant0),    32'd0);
        check("s6_rst_grant1", 32'(grant1),    32'd0);
        check("s6_rst_valid",  32'(out_valid), 32'd0);
        src0.delete();
        src1.delete();
        push_src(1'b0, 8'h61, 1'b1);
        push_src(1'b1, 8'h71, 1'b1);
        expect_beat(1'b0, 8'h61, 1'b1);
        expect_beat(1'b1, 8'h71, 1'b1);
        out_ready = 1'b1;
        drive_inputs();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) step();
        check("s6_drain", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
